pipelined_decoder: RTL and testbench
====================================

# pipelined_decoder

Decode stage for the pipelined MIPS core: holds the 32-entry register file, decodes rs/rt/rd/immediate, and registers the result into an ID/EX pipeline register with a valid/ready handshake. It sits between the fetch unit and the execute unit, with write-back feeding its register-file write port. Over the single-cycle decoder it adds a parametrised data width, zero-extension mode, write-through bypass, load-use hazard stalls, flush, and a stall counter.

## Interface
- DATA_WIDTH, 32, register/data width; must be ≥ 32. The immediate is extended to this width.
- LINK_REG, 31, destination register for JAL.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc_plus4  in  DATA_WIDTH  PC+4 of the instruction.
- reg_dst  in  1  control unit: 1 = rd, 0 = rt.
- jal  in  1  control unit: write LINK_REG.
- zero_ext  in  1  control unit: zero-extend the immediate (andi/ori/xori).
- id_ready  out  1  decode accepts if_instr this cycle.
- wb_en  in  1  write-back register write enable.
- wb_addr  in  5  write-back destination.
- wb_data  in  DATA_WIDTH  write-back data, already muxed by write-back.
- flush  in  1  squash the ID/EX contents and the current input.
- ex_ready  in  1  execute accepts ID/EX contents.
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_rs_data, ex_rt_data  out  DATA_WIDTH  operand values.
- ex_imm  out  DATA_WIDTH  extended immediate.
- ex_rs, ex_rt, ex_wr_addr  out  5  source and destination register numbers.
- ex_instr  out  32  instruction word.
- ex_pc_plus4  out  DATA_WIDTH  PC+4 value.
- stall_count  out  32  number of hazard stall cycles, saturating.

## Operation

**Register file**
- 32 × DATA_WIDTH registers; register 0 always reads 0 and ignores writes.
- Written on the rising edge when wb_en=1 and wb_addr≠0.
- Reads are combinational with write-through: if wb_en=1 and wb_addr equals the read address (≠0), the read returns wb_data in the same cycle.

**Decode**
- rs = instr[25:21], rt = instr[20:16].
- imm = zero_ext ? {0, instr[15:0]} : {instr[15] replicated, instr[15:0]}, extended to DATA_WIDTH.
- wr_addr: jal → LINK_REG; else reg_dst → instr[15:11]; else instr[20:16].
- For jal the link value is ex_pc_plus4; write-back selects it.

**Handshake and hazards**
- space = !ex_valid || ex_ready.
- Load-use hazard: ex_valid and ex_instr[31:26]=6'h23 (lw) and ex_rt≠0 and (ex_rt==rs || ex_rt==rt) of the instruction at the input. rt is always compared, which is conservative.
- id_ready = space && !hazard && !flush.
- The ID/EX register is updated only when space=1, with this priority:
  1. flush → ex_valid←0.
  2. hazard with if_valid → ex_valid←0 (bubble). stall_count increments, saturating at 2^32−1.
  3. if_valid → load all decoded fields, ex_valid←1.
  4. Otherwise → ex_valid←0.
- When space=0 and flush=0, ID/EX holds all fields unchanged.
- flush while ex_ready=0 still clears ex_valid next cycle; flush overrides the hold.

**Reset**
- All registers, all ex_* outputs and stall_count clear to 0. ex_valid=0.
- id_ready=1 during and after reset, provided flush=0 (ex_valid=0 implies space=1).

## Timing
- Latency: an instruction accepted at edge N appears on ex_* after edge N (one cycle).
- Throughput: one instruction per cycle with no hazards.
- A load-use hazard costs exactly one bubble cycle. The next cycle the lw has left ID/EX, so the hazard clears.
- A write-back in cycle N is visible to a decode in the same cycle N via the bypass.
- A reset asserted mid-stream discards ID/EX and the register file contents on the next edge.

## Test plan
- Reset, then wb_en=1 writing 0x1234 to r5 and 0xABCD to r0; decode rs=5, rt=0 → ex_rs_data=0x1234, ex_rt_data=0, ex_valid=1 one cycle after acceptance.
- Immediate 0x8001: zero_ext=0 → ex_imm=0xFFFF8001 (DATA_WIDTH=32). zero_ext=1 → 0x00008001. jal=1 → ex_wr_addr=31.
- Same-cycle write-back of r7=0x55 while decoding rs=7 → ex_rs_data=0x55.
- lw to r3 followed by add using r3 → id_ready=0 for one cycle, one bubble (ex_valid=0), stall_count=1, then the add issues. Repeat with r0 → no stall.
- ex_ready held 0 for 3 cycles → ex_* stable, id_ready=0. flush during the hold → ex_valid=0 next cycle.
- Saturation: force stall_count near 2^32−1, hazard twice → count stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/pipelined_decoder_if.sv
// Bus between fetch/control/write-back (master side) and the decode stage (slave side).
// Groups the instruction input, write-back port, and ID/EX output.
interface pipelined_decoder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  if_valid;
    logic [31:0]           if_instr;
    logic [DATA_WIDTH-1:0] if_pc_plus4;
    logic                  reg_dst;
    logic                  jal;
    logic                  zero_ext;
    logic                  id_ready;
    logic                  wb_en;
    logic [4:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  flush;
    logic                  ex_ready;
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_rs_data;
    logic [DATA_WIDTH-1:0] ex_rt_data;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [4:0]            ex_rs;
    logic [4:0]            ex_rt;
    logic [4:0]            ex_wr_addr;
    logic [31:0]           ex_instr;
    logic [DATA_WIDTH-1:0] ex_pc_plus4;
    logic [31:0]           stall_count;

    modport slave (
        input  if_valid, if_instr, if_pc_plus4, reg_dst, jal, zero_ext,
               wb_en, wb_addr, wb_data, flush, ex_ready,
        output id_ready, ex_valid, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_wr_addr, ex_instr, ex_pc_plus4, stall_count
    );

    modport master (
        output if_valid, if_instr, if_pc_plus4, reg_dst, jal, zero_ext,
               wb_en, wb_addr, wb_data, flush, ex_ready,
        input  id_ready, ex_valid, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_wr_addr, ex_instr, ex_pc_plus4, stall_count
    );
endinterface

// File: rtl/pipelined_decoder.sv
// MIPS decode stage: register file with write-through, field decode, and an
// ID/EX pipeline register with load-use bubbles, flush and a stall counter.
module pipelined_decoder #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [4:0] LINK_REG   = 5'd31
) (
    input logic                  clock,
    input logic                  reset,
    pipelined_decoder_if.slave   bus
);

    localparam logic [5:0] OP_LW = 6'h23;

    logic [DATA_WIDTH-1:0] regs_q [32];

    logic [4:0]            rsAddr;
    logic [4:0]            rtAddr;
    logic [DATA_WIDTH-1:0] rsData;
    logic [DATA_WIDTH-1:0] rtData;
    logic [DATA_WIDTH-1:0] immExt;
    logic [4:0]            wrAddr;
    logic                  space;
    logic                  hazard;

    logic                  exValid_q,    exValid_d;
    logic [DATA_WIDTH-1:0] exRsData_q,   exRsData_d;
    logic [DATA_WIDTH-1:0] exRtData_q,   exRtData_d;
    logic [DATA_WIDTH-1:0] exImm_q,      exImm_d;
    logic [4:0]            exRs_q,       exRs_d;
    logic [4:0]            exRt_q,       exRt_d;
    logic [4:0]            exWrAddr_q,   exWrAddr_d;
    logic [31:0]           exInstr_q,    exInstr_d;
    logic [DATA_WIDTH-1:0] exPcPlus4_q,  exPcPlus4_d;
    logic [31:0]           stallCount_q, stallCount_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // A same-cycle write-back is forwarded so decode never sees a stale value.
    always_comb begin
        rsAddr = bus.if_instr[25:21];
        rtAddr = bus.if_instr[20:16];
        rsData = regs_q[rsAddr];
        rtData = regs_q[rtAddr];
        if (rsAddr == 5'd0) begin
            rsData = '0;
        end else if (bus.wb_en && (bus.wb_addr == rsAddr)) begin
            rsData = bus.wb_data;
        end
        if (rtAddr == 5'd0) begin
            rtData = '0;
        end else if (bus.wb_en && (bus.wb_addr == rtAddr)) begin
            rtData = bus.wb_data;
        end
    end

    always_comb begin
        if (bus.zero_ext) begin
            immExt = {{(DATA_WIDTH-16){1'b0}}, bus.if_instr[15:0]};
        end else begin
            immExt = {{(DATA_WIDTH-16){bus.if_instr[15]}}, bus.if_instr[15:0]};
        end
        if (bus.jal) begin
            wrAddr = LINK_REG;
        end else if (bus.reg_dst) begin
            wrAddr = bus.if_instr[15:11];
        end else begin
            wrAddr = bus.if_instr[20:16];
        end
    end

    // rt is compared even for instructions that do not read it; a spare bubble is harmless.
    assign space  = !exValid_q || bus.ex_ready;
    assign hazard = exValid_q && (exInstr_q[31:26] == OP_LW) && (exRt_q != 5'd0) &&
                    ((exRt_q == rsAddr) || (exRt_q == rtAddr));
    assign bus.id_ready = space && !hazard && !bus.flush;

    always_comb begin
        exValid_d    = exValid_q;
        exRsData_d   = exRsData_q;
        exRtData_d   = exRtData_q;
        exImm_d      = exImm_q;
        exRs_d       = exRs_q;
        exRt_d       = exRt_q;
        exWrAddr_d   = exWrAddr_q;
        exInstr_d    = exInstr_q;
        exPcPlus4_d  = exPcPlus4_q;
        stallCount_d = stallCount_q;
        if (bus.flush) begin
            exValid_d = 1'b0;
        end else if (space) begin
            if (hazard && bus.if_valid) begin
                exValid_d = 1'b0;
                if (stallCount_q != 32'hFFFF_FFFF) begin
                    stallCount_d = stallCount_q + 32'd1;
                end
            end else if (bus.if_valid) begin
                exValid_d   = 1'b1;
                exRsData_d  = rsData;
                exRtData_d  = rtData;
                exImm_d     = immExt;
                exRs_d      = rsAddr;
                exRt_d      = rtAddr;
                exWrAddr_d  = wrAddr;
                exInstr_d   = bus.if_instr;
                exPcPlus4_d = bus.if_pc_plus4;
            end else begin
                exValid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            exValid_q    <= 1'b0;
            exRsData_q   <= '0;
            exRtData_q   <= '0;
            exImm_q      <= '0;
            exRs_q       <= '0;
            exRt_q       <= '0;
            exWrAddr_q   <= '0;
            exInstr_q    <= '0;
            exPcPlus4_q  <= '0;
            stallCount_q <= '0;
        end else begin
            exValid_q    <= exValid_d;
            exRsData_q   <= exRsData_d;
            exRtData_q   <= exRtData_d;
            exImm_q      <= exImm_d;
            exRs_q       <= exRs_d;
            exRt_q       <= exRt_d;
            exWrAddr_q   <= exWrAddr_d;
            exInstr_q    <= exInstr_d;
            exPcPlus4_q  <= exPcPlus4_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign bus.ex_valid    = exValid_q;
    assign bus.ex_rs_data  = exRsData_q;
    assign bus.ex_rt_data  = exRtData_q;
    assign bus.ex_imm      = exImm_q;
    assign bus.ex_rs       = exRs_q;
    assign bus.ex_rt       = exRt_q;
    assign bus.ex_wr_addr  = exWrAddr_q;
    assign bus.ex_instr    = exInstr_q;
    assign bus.ex_pc_plus4 = exPcPlus4_q;
    assign bus.stall_count = stallCount_q;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Directed bench for pipelined_decoder: register file, immediates, bypass,
// load-use stalls, backpressure hold, flush, counter saturation and mid-stream reset.
module tb_pipelined_decoder;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    pipelined_decoder_if #(.DATA_WIDTH(32)) bus ();

    pipelined_decoder #(.DATA_WIDTH(32), .LINK_REG(5'd31)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 11'h000};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic regDst,
                                 input logic isJal, input logic zeroExt);
        bus.if_valid    = valid;
        bus.if_instr    = instr;
        bus.if_pc_plus4 = pc;
        bus.reg_dst     = regDst;
        bus.jal         = isJal;
        bus.zero_ext    = zeroExt;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.wb_en       = 1'b0;
        bus.wb_addr     = 5'd0;
        bus.wb_data     = '0;
        bus.flush       = 1'b0;
        bus.ex_ready    = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_ex_valid", bus.ex_valid, 0);
        checkOutput("reset_stall_count", bus.stall_count, 0);
        checkOutput("reset_id_ready", bus.id_ready, 1);
        checkOutput("reset_ex_rs_data", bus.ex_rs_data, 0);

        reset       = 1'b0;
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd5;
        bus.wb_data = 32'h1234;
        tick();
        bus.wb_addr = 5'd0;
        bus.wb_data = 32'hABCD;
        tick();
        bus.wb_en   = 1'b0;

        applyStimulus(1'b1, iType(6'h0d, 5'd5, 5'd0, 16'h8001), 32'h100, 1'b1, 1'b0, 1'b0);
        checkOutput("accept_id_ready", bus.id_ready, 1);
        tick();
        checkOutput("rf_ex_valid", bus.ex_valid, 1);
        checkOutput("rf_rs_data", bus.ex_rs_data, 32'h1234);
        checkOutput("rf_r0_data", bus.ex_rt_data, 0);
        checkOutput("sign_ext_imm", bus.ex_imm, 32'hFFFF8001);
        checkOutput("rd_wr_addr", bus.ex_wr_addr, 16);
        checkOutput("ex_rs", bus.ex_rs, 5);
        checkOutput("ex_pc_plus4", bus.ex_pc_plus4, 32'h100);
        checkOutput("ex_instr", bus.ex_instr, 32'h34A08001);

        applyStimulus(1'b1, iType(6'h0d, 5'd5, 5'd2, 16'h8001), 32'h104, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("zero_ext_imm", bus.ex_imm, 32'h00008001);
        checkOutput("rt_wr_addr", bus.ex_wr_addr, 2);

        applyStimulus(1'b1, iType(6'h03, 5'd0, 5'd0, 16'h0010), 32'h108, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("jal_wr_addr", bus.ex_wr_addr, 31);

        // Write-back and decode of r7 in the same cycle.
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'h55;
        applyStimulus(1'b1, iType(6'h0d, 5'd7, 5'd0, 16'h0), 32'h10C, 1'b0, 1'b0, 1'b0);
        tick();
        bus.wb_en = 1'b0;
        checkOutput("bypass_rs_data", bus.ex_rs_data, 32'h55);
        applyStimulus(1'b1, iType(6'h0d, 5'd0, 5'd7, 16'h0), 32'h110, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("stored_rt_data", bus.ex_rt_data, 32'h55);

        applyStimulus(1'b1, iType(6'h23, 5'd0, 5'd3, 16'h4), 32'h114, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, rType(5'd3, 5'd4, 5'd8), 32'h118, 1'b1, 1'b0, 1'b0);
        checkOutput("hazard_id_ready", bus.id_ready, 0);
        tick();
        checkOutput("bubble_ex_valid", bus.ex_valid, 0);
        checkOutput("bubble_stall_count", bus.stall_count, 1);
        checkOutput("after_bubble_id_ready", bus.id_ready, 1);
        tick();
        checkOutput("add_issue_valid", bus.ex_valid, 1);
        checkOutput("add_issue_rs", bus.ex_rs, 3);
        checkOutput("add_issue_wr_addr", bus.ex_wr_addr, 8);

        applyStimulus(1'b1, iType(6'h23, 5'd0, 5'd0, 16'h4), 32'h11C, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, rType(5'd0, 5'd4, 5'd9), 32'h120, 1'b1, 1'b0, 1'b0);
        checkOutput("r0_no_hazard_ready", bus.id_ready, 1);
        tick();
        checkOutput("r0_add_valid", bus.ex_valid, 1);
        checkOutput("r0_add_wr_addr", bus.ex_wr_addr, 9);
        checkOutput("r0_stall_count", bus.stall_count, 1);

        applyStimulus(1'b1, iType(6'h0d, 5'd5, 5'd6, 16'h0042), 32'h124, 1'b0, 1'b0, 1'b0);
        tick();
        bus.ex_ready = 1'b0;
        applyStimulus(1'b1, iType(6'h0d, 5'd5, 5'd7, 16'h0001), 32'h128, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_id_ready", bus.id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_ex_instr", bus.ex_instr, 32'h34A60042);
            checkOutput("hold_ex_valid", bus.ex_valid, 1);
            checkOutput("hold_ex_imm", bus.ex_imm, 32'h42);
            checkOutput("hold_id_ready_loop", bus.id_ready, 0);
        end
        bus.flush = 1'b1;
        #1;
        checkOutput("flush_id_ready", bus.id_ready, 0);
        tick();
        bus.flush = 1'b0;
        checkOutput("flush_ex_valid", bus.ex_valid, 0);
        bus.ex_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        force dut.stallCount_q = 32'hFFFF_FFFE;
        #1;
        release dut.stallCount_q;
        applyStimulus(1'b1, iType(6'h23, 5'd0, 5'd3, 16'h4), 32'h12C, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, rType(5'd3, 5'd4, 5'd8), 32'h130, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("sat_first_stall", bus.stall_count, 32'hFFFFFFFF);
        tick();
        applyStimulus(1'b1, iType(6'h23, 5'd0, 5'd3, 16'h4), 32'h134, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, rType(5'd3, 5'd4, 5'd8), 32'h138, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("sat_second_stall", bus.stall_count, 32'hFFFFFFFF);
        checkOutput("sat_bubble_valid", bus.ex_valid, 0);

        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("midreset_ex_valid", bus.ex_valid, 0);
        checkOutput("midreset_stall_count", bus.stall_count, 0);
        checkOutput("midreset_id_ready", bus.id_ready, 1);
        reset = 1'b0;
        applyStimulus(1'b1, iType(6'h0d, 5'd5, 5'd7, 16'h0), 32'h200, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("midreset_r5_cleared", bus.ex_rs_data, 0);
        checkOutput("midreset_r7_cleared", bus.ex_rt_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
